// File: rtl/fir_filter_core.sv
// rtl/fir_filter_core.sv - 8-tap fixed-coefficient direct-form FIR filter, one sample per clock.
// Optional output saturation selected by defining FIR_OUT_SAT_EN; default build wraps to OUT_WIDTH LSBs.
module fir_filter_core #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NTAPS      = 8,
    parameter int OUT_WIDTH  = 32,
    parameter logic [NTAPS*COEF_WIDTH-1:0] COEFFS = {
        16'd256, 16'd1024, 16'd3072, 16'd4864,
        16'd4864, 16'd3072, 16'd1024, 16'd256
    }
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic signed [OUT_WIDTH-1:0]  data_out
);

    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NTAPS);
    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

    logic signed [DATA_WIDTH-1:0] r_x [NTAPS];
    logic signed [PROD_WIDTH-1:0] w_prod [NTAPS];
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic signed [OUT_WIDTH-1:0]  w_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k] <= '0;
            end
        end else begin
            r_x[0] <= data_in;
            for (int k = 1; k < NTAPS; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

    // Operands are sign-extended to the product width so the multiply is full precision.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_prod[k] = $signed({{COEF_WIDTH{r_x[k][DATA_WIDTH-1]}}, r_x[k]})
                      * $signed({{DATA_WIDTH{COEFFS[k*COEF_WIDTH+COEF_WIDTH-1]}},
                                 COEFFS[k*COEF_WIDTH +: COEF_WIDTH]});
            w_sum = w_sum + {{(ACC_WIDTH-PROD_WIDTH){w_prod[k][PROD_WIDTH-1]}}, w_prod[k]};
        end
    end

`ifdef FIR_OUT_SAT_EN
    // Bits above the output sign bit must all equal it, otherwise the sum is out of range.
    logic [ACC_WIDTH-OUT_WIDTH:0] w_hi;
    assign w_hi = w_sum[ACC_WIDTH-1:OUT_WIDTH-1];

    always_comb begin
        if (!w_sum[ACC_WIDTH-1] && (|w_hi)) begin
            w_out = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (w_sum[ACC_WIDTH-1] && !(&w_hi)) begin
            w_out = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            w_out = w_sum[OUT_WIDTH-1:0];
        end
    end
`else
    logic w_unused_sum;
    assign w_unused_sum = &{1'b0, w_sum};
    assign w_out        = w_sum[OUT_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else begin
            data_out <= w_out;
        end
    end

endmodule

// File: tb/tb_fir_filter_core.sv
// tb/tb_fir_filter_core.sv - self-checking bench for fir_filter_core (32-bit and 24-bit output instances).
module tb_fir_filter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [15:0] data_in;
    logic signed [31:0] dout32;
    logic signed [23:0] dout24;

    fir_filter_core dut32 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (dout32)
    );

    fir_filter_core #(.OUT_WIDTH(24)) dut24 (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (dout24)
    );

    localparam int H [8] = '{256, 1024, 3072, 4864, 4864, 3072, 1024, 256};

    int     n_checks = 0;
    int     n_errors = 0;
    int     xm [8];
    longint q32 [$];
    longint q24 [$];

    typedef struct {
        int din;
        int exp_out;
    } vec_t;

    vec_t imp [10];

    function automatic longint model_sum();
        longint s = 0;
        for (int k = 0; k < 8; k++) s += longint'(H[k]) * longint'(xm[k]);
        return s;
    endfunction

    function automatic longint conv24(longint s);
`ifdef FIR_OUT_SAT_EN
        if (s > 64'sd8388607)  return 64'sd8388607;
        if (s < -64'sd8388608) return -64'sd8388608;
        return s;
`else
        logic [23:0] t;
        t = s[23:0];
        return longint'($signed(t));
`endif
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) xm[k] = 0;
        q32.delete();
        q24.delete();
        q32.push_back(0);
        q24.push_back(0);
    endtask

    task automatic step(input int d);
        longint s;
        @(negedge clk);
        data_in = 16'(d);
        for (int k = 7; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = d;
        s = model_sum();
        q32.push_back(s);
        q24.push_back(conv24(s));
        @(posedge clk);
        #1;
        if (q32.size() < 2 || q24.size() < 2) begin
            check("scoreboard_depth", longint'(q32.size()), 2);
        end else begin
            check("sb_out32", longint'(dout32), q32.pop_front());
            check("sb_out24", longint'(dout24), q24.pop_front());
        end
    endtask

    // Asserts reset between edges, holds it for hold_cycles edges, then releases it between edges.
    task automatic do_reset(input int hold_cycles);
        @(negedge clk);
        #2;
        rst = 1'b0;
        data_in = 16'($urandom_range(0, 65535));
        #1;
        check("async_reset_out32", longint'(dout32), 0);
        check("async_reset_out24", longint'(dout24), 0);
        repeat (hold_cycles) begin
            @(negedge clk);
            data_in = 16'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
            check("reset_hold_out32", longint'(dout32), 0);
            check("reset_hold_out24", longint'(dout24), 0);
        end
        rst = 1'b1;
        data_in = '0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        data_in = '0;
        imp[0] = '{1, 0};
        imp[1] = '{0, 256};
        imp[2] = '{0, 1024};
        imp[3] = '{0, 3072};
        imp[4] = '{0, 4864};
        imp[5] = '{0, 4864};
        imp[6] = '{0, 3072};
        imp[7] = '{0, 1024};
        imp[8] = '{0, 256};
        imp[9] = '{0, 0};
        model_clear();

        do_reset(5);

        for (int i = 0; i < 10; i++) begin
            step(imp[i].din);
            check("impulse_tbl_out32", longint'(dout32), imp[i].exp_out);
            check("impulse_tbl_out24", longint'(dout24), imp[i].exp_out);
        end

        repeat (10) step(32767);
        check("step_pos_out32", longint'(dout32), 603961344);
`ifdef FIR_OUT_SAT_EN
        check("step_pos_out24", longint'(dout24), 8388607);
`else
        check("step_pos_out24", longint'(dout24), -18432);
`endif

        repeat (10) step(-32768);
        check("step_neg_out32", longint'(dout32), -603979776);
`ifdef FIR_OUT_SAT_EN
        check("step_neg_out24", longint'(dout24), -8388608);
`else
        check("step_neg_out24", longint'(dout24), 0);
`endif

        for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 1000 : -1000);
        check("nyquist_out32", longint'(dout32), 0);

        for (int i = 0; i < 40; i++) step(int'($urandom_range(0, 65535)) - 32768);

        repeat (4) step(32767);
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            step(0);
            check("post_reset_zero32", longint'(dout32), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
